// File: rtl/pll_dyn_ctrl.sv
// Dynamic PLL divider controller: selects 720p/480p dividers, sequences PLL reset and lock qualification.
// Optional PLL_DYN_RETRY_EN adds a per-attempt lock timeout with four attempts before giving up.
module pll_dyn_ctrl #(
    parameter int RESET_CYCLES   = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       mode,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] idsel,
    output logic [5:0] fbdsel,
    output logic [6:0] mdsel,
    output logic [6:0] odsel0,
    output logic [6:0] odsel1,
    output logic       busy,
    output logic       ready,
    output logic       err
);
    localparam int RW = $clog2(RESET_CYCLES) + 1;
    localparam int SW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);

    // Select fields are (2^W - divider).
    localparam logic [5:0] IDSEL_ALL  = 6'(64 - 1);
    localparam logic [5:0] FBDSEL_ALL = 6'(64 - 1);
    localparam logic [6:0] MDSEL_720  = 7'(128 - 55);
    localparam logic [6:0] OD0_720    = 7'(128 - 4);
    localparam logic [6:0] OD1_720    = 7'(128 - 20);
    localparam logic [6:0] MDSEL_480  = 7'(128 - 40);
    localparam logic [6:0] OD0_480    = 7'(128 - 8);
    localparam logic [6:0] OD1_480    = 7'(128 - 40);

`ifdef PLL_DYN_RETRY_EN
    localparam int MAX_ATTEMPTS = 4;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int AW = $clog2(MAX_ATTEMPTS) + 1;
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [AW-1:0] ATTEMPT_LAST = AW'(MAX_ATTEMPTS - 1);
    logic [TW-1:0] to_cnt_q;
    logic [AW-1:0] attempt_q;
    logic          err_q;
`endif

    typedef enum logic [1:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_LOCKED,
        ST_IDLE_FAIL
    } state_t;

    state_t        state_q;
    logic [RW-1:0] rst_cnt_q;
    logic [SW-1:0] stab_cnt_q;
    logic          pll_reset_q, busy_q, ready_q;
    logic [5:0]    idsel_q, fbdsel_q;
    logic [6:0]    mdsel_q, odsel0_q, odsel1_q;
    logic          sync1_q, lock_s_q;

    // The synchronizer is flushed while the PLL is held in reset so that a lock level
    // sampled before the reset took effect can never count towards stability.
    always_ff @(posedge clk) begin
        if (rst || pll_reset_q) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RESET;
            rst_cnt_q   <= '0;
            stab_cnt_q  <= '0;
            pll_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            idsel_q     <= IDSEL_ALL;
            fbdsel_q    <= FBDSEL_ALL;
            mdsel_q     <= MDSEL_720;
            odsel0_q    <= OD0_720;
            odsel1_q    <= OD1_720;
`ifdef PLL_DYN_RETRY_EN
            to_cnt_q    <= '0;
            attempt_q   <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_q     <= ST_WAIT_LOCK;
                        pll_reset_q <= 1'b0;
                        rst_cnt_q   <= '0;
                        stab_cnt_q  <= '0;
`ifdef PLL_DYN_RETRY_EN
                        to_cnt_q    <= '0;
`endif
                    end else if (rst_cnt_q != '1) begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (stab_cnt_q >= STABLE_MAX) begin
                        state_q    <= ST_LOCKED;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        stab_cnt_q <= '0;
`ifdef PLL_DYN_RETRY_EN
                        attempt_q  <= '0;
                    end else if (to_cnt_q >= TIMEOUT_MAX) begin
                        to_cnt_q    <= '0;
                        stab_cnt_q  <= '0;
                        pll_reset_q <= 1'b1;
                        if (attempt_q == ATTEMPT_LAST) begin
                            state_q <= ST_IDLE_FAIL;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= ST_RESET;
                            attempt_q <= attempt_q + 1'b1;
                        end
`endif
                    end else begin
                        if (!lock_s_q) begin
                            stab_cnt_q <= '0;
                        end else if (stab_cnt_q != '1) begin
                            stab_cnt_q <= stab_cnt_q + 1'b1;
                        end
`ifdef PLL_DYN_RETRY_EN
                        if (to_cnt_q != '1) begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
`endif
                    end
                end
                ST_LOCKED, ST_IDLE_FAIL: begin
                    // A request wins over a simultaneous lock loss so the new mode is applied.
                    if (req) begin
                        state_q     <= ST_RESET;
                        rst_cnt_q   <= '0;
                        pll_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
                        ready_q     <= 1'b0;
                        idsel_q     <= IDSEL_ALL;
                        fbdsel_q    <= FBDSEL_ALL;
                        mdsel_q     <= mode ? MDSEL_480 : MDSEL_720;
                        odsel0_q    <= mode ? OD0_480 : OD0_720;
                        odsel1_q    <= mode ? OD1_480 : OD1_720;
`ifdef PLL_DYN_RETRY_EN
                        attempt_q   <= '0;
                        err_q       <= 1'b0;
`endif
                    end else if (state_q == ST_LOCKED && !lock_s_q) begin
                        state_q     <= ST_RESET;
                        rst_cnt_q   <= '0;
                        pll_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
                        ready_q     <= 1'b0;
                    end
                end
                default: state_q <= ST_RESET;
            endcase
        end
    end

    assign pll_reset = pll_reset_q;
    assign idsel     = idsel_q;
    assign fbdsel    = fbdsel_q;
    assign mdsel     = mdsel_q;
    assign odsel0    = odsel0_q;
    assign odsel1    = odsel1_q;
    assign busy      = busy_q;
    assign ready     = ready_q;
`ifdef PLL_DYN_RETRY_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif
endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Self-checking bench for pll_dyn_ctrl: directed scenario sequence with randomized modes,
// glitch positions and request timing, checked against a waveform-level reference model.
module tb_pll_dyn_ctrl;
    localparam int RC   = 4;
    localparam int SC   = 8;
    localparam int TC   = 32;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst, req, mode, pll_lock;
    logic       pll_reset, busy, ready, err;
    logic [5:0] idsel, fbdsel;
    logic [6:0] mdsel, odsel0, odsel1;

    int   compared   = 0;
    int   mismatched = 0;
    logic cur_mode   = 1'b0;

    always #5 clk = ~clk;

    pll_dyn_ctrl #(
        .RESET_CYCLES  (RC),
        .STABLE_CYCLES (SC),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .mode     (mode),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .idsel    (idsel),
        .fbdsel   (fbdsel),
        .mdsel    (mdsel),
        .odsel0   (odsel0),
        .odsel1   (odsel1),
        .busy     (busy),
        .ready    (ready),
        .err      (err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int mdiv(input logic m);
        return m ? 40 : 55;
    endfunction
    function automatic int odiv0(input logic m);
        return m ? 8 : 4;
    endfunction
    function automatic int odiv1(input logic m);
        return m ? 40 : 20;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_divs(input string tag, input logic m);
        check_val({tag, "_idsel"},  32'(idsel),  64 - 1);
        check_val({tag, "_fbdsel"}, 32'(fbdsel), 64 - 1);
        check_val({tag, "_mdsel"},  32'(mdsel),  128 - mdiv(m));
        check_val({tag, "_odsel0"}, 32'(odsel0), 128 - odiv0(m));
        check_val({tag, "_odsel1"}, 32'(odsel1), 128 - odiv1(m));
    endtask

    // Edges until pll_reset reaches level; optionally pulses req before edge req_at.
    task automatic wait_reset_level(input string tag, input logic level, input int expected,
                                    input int req_at, input logic req_mode);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 200) begin
            req = (n + 1 == req_at);
            if (n + 1 == req_at) mode = req_mode;
            tick();
            req = 1'b0;
            n++;
            if (pll_reset === level) seen = 1;
        end
        check_val(tag, seen ? n : -1, expected);
    endtask

    // Called on the sample where pll_reset has just fallen. lin[k] is the pll_lock level
    // presented to the k-th edge; the controller sees it SYNC edges later, and ready must
    // follow one edge after SC consecutive seen-high edges.
    task automatic lock_phase(input string tag, input int glitch_p, input int req_k,
                              input logic req_mode);
        logic lin[64];
        logic seen_lock[64];
        int   t_ready = -1;
        int   run = 0;
        for (int k = 0; k < 64; k++) lin[k] = (k != glitch_p);
        for (int t = 0; t < 64; t++) seen_lock[t] = (t > SYNC) ? lin[t - SYNC] : 1'b0;
        for (int t = 1; t < 63; t++) begin
            run = seen_lock[t] ? run + 1 : 0;
            if (run == SC && t_ready < 0) t_ready = t + 1;
        end
        for (int k = 1; k <= t_ready + 1; k++) begin
            pll_lock = lin[k];
            req = (k == req_k);
            if (k == req_k) mode = req_mode;
            tick();
            req = 1'b0;
            check_bit({tag, "_ready"}, ready, k >= t_ready);
            check_bit({tag, "_busy"}, busy, k < t_ready);
            check_bit({tag, "_pll_reset"}, pll_reset, 1'b0);
        end
        pll_lock = 1'b1;
        check_divs({tag, "_locked"}, cur_mode);
        $display("txn %s: glitch=%0d req_k=%0d ready_after=%0d edges", tag, glitch_p, req_k, t_ready);
    endtask

    task automatic full_seq(input string tag, input int glitch_p, input int req_k, input logic req_mode);
        wait_reset_level({tag, "_reset_len"}, 1'b0, RC, 0, 1'b0);
        check_divs({tag, "_wait"}, cur_mode);
        lock_phase(tag, glitch_p, req_k, req_mode);
    endtask

    task automatic accept(input string tag, input logic m);
        req = 1'b1;
        mode = m;
        tick();
        req = 1'b0;
        cur_mode = m;
        $display("txn %s: req accepted mode=%0d", tag, m);
        check_divs(tag, m);
        check_bit({tag, "_pll_reset"}, pll_reset, 1'b1);
        check_bit({tag, "_ready"}, ready, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b1);
        check_bit({tag, "_err"}, err, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_divs(tag, 1'b0);
        check_bit({tag, "_pll_reset"}, pll_reset, 1'b1);
        check_bit({tag, "_busy"}, busy, 1'b1);
        check_bit({tag, "_ready"}, ready, 1'b0);
        check_bit({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        logic m;
        rst = 1'b1; req = 1'b0; mode = 1'b0; pll_lock = 1'b1;
        repeat (3) tick();
        $display("txn reset: checking reset outputs");
        check_reset_outputs("rst_hold");

        rst = 1'b0;
        cur_mode = 1'b0;
        $display("txn reset: released with lock tied high");
        full_seq("rst_release", 0, 0, 1'b0);

        // Mode changes from LOCKED; the first one is 480p.
        for (int i = 0; i < 4; i++) begin
            m = (i == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) tick();
            check_bit("locked_idle_ready", ready, 1'b1);
            accept($sformatf("modechg%0d", i), m);
            full_seq($sformatf("modechg%0d", i), 0, 0, 1'b0);
        end

        // Lock glitch at stable count 6, then at a random position.
        accept("glitch6", 1'(($urandom_range(0, 1))));
        full_seq("glitch6", 7, 0, 1'b0);
        accept("glitch_rand", 1'(($urandom_range(0, 1))));
        full_seq("glitch_rand", $urandom_range(1, 8), 0, 1'b0);

        // Requests during RESET and WAIT_LOCK are ignored.
        m = 1'(($urandom_range(0, 1)));
        accept("req_ignored", m);
        wait_reset_level("req_in_reset", 1'b0, RC, 2, ~m);
        check_divs("req_in_reset", m);
        lock_phase("req_in_wait", 0, $urandom_range(1, 6), ~m);

        // Lock loss in LOCKED.
        pll_lock = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_bit("lockloss_ready", ready, k < 3);
            check_bit("lockloss_pll_reset", pll_reset, k == 3);
            check_bit("lockloss_busy", busy, k == 3);
        end
        check_divs("lockloss", cur_mode);
        pll_lock = 1'b1;
        $display("txn lockloss: ready dropped 3 edges after lock loss");
        full_seq("lockloss_relock", 0, 0, 1'b0);

        // Request coinciding with lock loss wins.
        m = ~cur_mode;
        pll_lock = 1'b0;
        tick();
        tick();
        req = 1'b1;
        mode = m;
        tick();
        req = 1'b0;
        cur_mode = m;
        $display("txn req_vs_lockloss: req mode=%0d with lock loss", m);
        check_divs("req_vs_lockloss", m);
        check_bit("req_vs_lockloss_pll_reset", pll_reset, 1'b1);
        check_bit("req_vs_lockloss_ready", ready, 1'b0);
        pll_lock = 1'b1;
        full_seq("req_vs_lockloss", 0, 0, 1'b0);

        // Reset in the middle of WAIT_LOCK.
        accept("mid_rst", 1'b1);
        wait_reset_level("mid_rst_reset_len", 1'b0, RC, 0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        $display("txn mid_rst: rst asserted in WAIT_LOCK");
        check_reset_outputs("mid_rst");
        tick();
        rst = 1'b0;
        cur_mode = 1'b0;
        full_seq("mid_rst_release", 0, 0, 1'b0);

        // Lock never arrives.
        rst = 1'b1;
        pll_lock = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        cur_mode = 1'b0;
`ifdef PLL_DYN_RETRY_EN
        for (int a = 1; a <= 4; a++) begin
            wait_reset_level($sformatf("retry%0d_fall", a), 1'b0, RC, 0, 1'b0);
            wait_reset_level($sformatf("retry%0d_timeout", a), 1'b1, TC + 1, 0, 1'b0);
            check_bit($sformatf("retry%0d_err", a), err, a == 4);
            check_bit($sformatf("retry%0d_busy", a), busy, a != 4);
            $display("txn retry: attempt %0d timed out", a);
        end
        repeat (5) tick();
        check_bit("idle_fail_err", err, 1'b1);
        check_bit("idle_fail_pll_reset", pll_reset, 1'b1);
        check_bit("idle_fail_busy", busy, 1'b0);
        pll_lock = 1'b1;
        accept("fail_recover", 1'(($urandom_range(0, 1))));
        full_seq("fail_recover", 0, 0, 1'b0);
`else
        wait_reset_level("nolock_reset_len", 1'b0, RC, 0, 1'b0);
        for (int k = 0; k < 3 * TC; k++) begin
            tick();
            check_bit("nolock_pll_reset", pll_reset, 1'b0);
            check_bit("nolock_err", err, 1'b0);
        end
        $display("txn nolock: waited %0d edges without timeout", 3 * TC);
        rst = 1'b1;
        pll_lock = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        full_seq("nolock_restart", 0, 0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pll_dyn_ctrl.md
PLL_DYN_CTRL -- requirements
Module: pll_dyn_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: number of clk cycles pll_reset is held high per attempt.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024: number of consecutive synchronized-lock-high cycles required before reporting ready.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1048576: maximum WAIT_LOCK cycles per attempt.
REQ-004 SHALL have the following ports:
- clk, input, 1: free-running 27 MHz PLL reference clock; never a PLL output.
- rst, input, 1: synchronous, active-high reset.
- req, input, 1: reconfiguration request, single-cycle pulse.
- mode, input, 1: 0 = 720p (74.25 MHz pixel / 371.25 MHz serial); 1 = 480p (27 / 135 MHz).
- pll_lock, input, 1: PLL LOCK, asynchronous to clk.
- pll_reset, output, 1: drives PLL RESET.
- idsel, output, 6: drives PLL IDSEL.
- fbdsel, output, 6: drives PLL FBDSEL.
- mdsel, output, 7: drives PLL MDSEL.
- odsel0, output, 7: drives PLL ODSEL0.
- odsel1, output, 7: drives PLL ODSEL1.
- busy, output, 1: reconfiguration in progress.
- ready, output, 1: PLL stably locked at the active mode.
- err, output, 1: lock attempts exhausted.

Function
REQ-005 SHALL encode each divider select as (2^W - divider), where W is the field width.
REQ-006 SHALL drive the mode 0 dividers IDIV=1, FBDIV=1, MDIV=55, ODIV0=4, ODIV1=20, giving idsel=63, fbdsel=63, mdsel=73, odsel0=124, odsel1=108.
REQ-007 SHALL drive the mode 1 dividers IDIV=1, FBDIV=1, MDIV=40, ODIV0=8, ODIV1=40, giving idsel=63, fbdsel=63, mdsel=88, odsel0=120, odsel1=88.
REQ-008 SHALL pass pll_lock through a 2-flop synchronizer (lock_s), giving 2 cycles of latency.
REQ-009 SHALL implement a state machine with states RESET, WAIT_LOCK, LOCKED, IDLE_FAIL.
REQ-010 SHALL accept req only in LOCKED or IDLE_FAIL, sampling mode in the acceptance cycle; in the next cycle it SHALL update the divider outputs, enter RESET, and set busy=1, ready=0, err=0.
REQ-011 SHALL ignore req in RESET and WAIT_LOCK: no queuing, and the mode sample is discarded.
REQ-012 In RESET, SHALL hold pll_reset=1 for exactly RESET_CYCLES cycles, then enter WAIT_LOCK with pll_reset=0.
REQ-013 In WAIT_LOCK, SHALL count consecutive lock_s=1 cycles, restarting the count on any lock_s=0; when the count reaches STABLE_CYCLES it SHALL enter LOCKED with ready=1 and busy=0 in the following cycle.
REQ-014 In LOCKED, lock_s=0 for one cycle SHALL set ready=0 in the next cycle and re-enter RESET with the same dividers and busy=1.
REQ-015 If req and lock_s=0 occur in the same LOCKED cycle, req SHALL take precedence and the new mode SHALL be applied.
REQ-016 Divider outputs SHALL change only on REQ-010 acceptance or at reset, and SHALL never change while pll_reset=0.
REQ-017 Counters SHALL be sized to $clog2 of their parameter plus 1, and SHALL saturate rather than wrap.

Reset
REQ-018 While rst=1, outputs SHALL be: pll_reset=1, dividers at mode 0 values, busy=1, ready=0, err=0; state SHALL be RESET and all counters 0.
REQ-019 The first cycle after rst falls SHALL start a full mode 0 RESET sequence with no req needed.
REQ-020 rst asserted mid-sequence SHALL abort the sequence and restore the REQ-018 outputs at the next clk edge.

Configuration
REQ-021 With PLL_DYN_RETRY_EN defined, WAIT_LOCK exceeding TIMEOUT_CYCLES SHALL increment the attempt count and return to RESET.
REQ-022 With PLL_DYN_RETRY_EN defined, a timeout on the 4th attempt SHALL enter IDLE_FAIL with err=1, busy=0, pll_reset=1.
REQ-023 With PLL_DYN_RETRY_EN defined, the attempt count SHALL clear on entry to LOCKED or on req acceptance.
REQ-024 Without PLL_DYN_RETRY_EN, WAIT_LOCK SHALL wait indefinitely, err SHALL be constant 0, IDLE_FAIL SHALL be unreachable, and no timeout counter SHALL be synthesized.

Verification
REQ-025 The bench SHALL use RESET_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32.
REQ-026 Scenario: release rst with pll_lock tied 1 -> pll_reset high for exactly 4 cycles, mdsel=73, ready rises 2 (sync) + 8 (stable) + 1 cycles after pll_reset falls, busy falls in the same cycle.
REQ-027 Scenario: in LOCKED, pulse req with mode=1 -> next cycle mdsel=88, odsel0=120, odsel1=88, pll_reset=1, ready=0; ready returns after a full sequence.
REQ-028 Scenario: in WAIT_LOCK, toggle pll_lock low for 1 cycle at stable count 6 -> count restarts; ready is delayed by the restart.
REQ-029 Scenario: in LOCKED, drop pll_lock -> ready=0 3 cycles later (2 sync + 1), pll_reset reasserts, dividers unchanged.
REQ-030 Scenario (PLL_DYN_RETRY_EN defined): pll_lock held 0 -> 4 reset pulses, then err=1, busy=0; a subsequent req clears err and restarts the sequence.
REQ-031 Scenario: req during RESET and rst mid-WAIT_LOCK -> req has no effect; rst restores mode 0 outputs with pll_reset=1 at the next edge.
